// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants for the RMII receive path.
// CRC-32 parameters, status bit map and receive FSM state codes.
package eth_pkg;

  localparam logic [1:0] ETH_PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] ETH_SFD_DIBIT      = 2'b11;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

  localparam int ETH_MIN_FRAME = 64;

  localparam int STAT_FCS_BAD = 0;
  localparam int STAT_ALIGN   = 1;
  localparam int STAT_RUNT    = 2;
  localparam int STAT_GIANT   = 3;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 register (LSB of each byte first).
// init has priority over en; residue is read straight from crc.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] nxt;

  // fold one byte through the reflected polynomial, bit 0 first
  always_comb begin
    nxt = crc;
    for (int i = 0; i < 8; i++) begin
      nxt = (nxt >> 1)
          ^ (CRC32_POLY_REFL & {32{nxt[0] ^ data[i]}});
    end
  end

  // CRC state: reload on init, advance on each accepted byte
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC32_INIT;
    end else if (init) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= nxt;
    end
  end

endmodule

// File: rtl/rmii_rx.sv
// RMII receive front end: preamble/SFD strip, byte assembly,
// FCS/runt/giant/alignment checks with end-of-frame status.
module rmii_rx
  import eth_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MAX_FRAME_BYTES     = 1522,
  parameter bit CHECK_FCS           = 1'b1
) (
  input  logic        clk_50MHz,
  input  logic        rst_n,
  input  logic        CRS,
  input  logic        RX0,
  input  logic        RX1,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [3:0]  rx_status,
  output logic [10:0] rx_len
);

  logic        crs_q;
  logic [1:0]  dib_q;
  logic        cv;
  logic        ce;
  logic [1:0]  cd;

  logic [1:0]  state;
  logic [4:0]  pcount;
  logic [1:0]  didx;
  logic [5:0]  sh;
  logic [15:0] byte_cnt;
  logic        giant;

  logic        in_data;
  logic        pre_ok;
  logic        room;
  logic        byte_go;
  logic        crc_en;
  logic        sfd_hit;
  logic        crc_init;
  logic        eof_go;
  logic [7:0]  byte_full;
  logic [31:0] crc;
  logic [3:0]  stat;
  logic [10:0] len_sat;

  // sample CRS_DV/RXD, then resolve commit vs carrier end
  // using the following CRS sample (CRS_DV toggles mid-byte)
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      crs_q <= 1'b0;
      dib_q <= 2'b00;
      cv    <= 1'b0;
      ce    <= 1'b0;
      cd    <= 2'b00;
    end else begin
      crs_q <= CRS;
      dib_q <= {RX1, RX0};
      cv    <= crs_q | CRS;
      ce    <= ~crs_q & ~CRS;
      cd    <= dib_q;
    end
  end

  assign in_data   = (state == ST_DATA);
  assign pre_ok    = int'(pcount) >= MIN_PREAMBLE_DIBITS;
  assign room      = int'(byte_cnt) < MAX_FRAME_BYTES;
  assign byte_go   = in_data && cv && (didx == 2'd3);
  assign crc_en    = byte_go && room;
  assign eof_go    = in_data && ce;
  assign sfd_hit   = cv && !in_data && (state != ST_DROP)
                  && (cd == ETH_SFD_DIBIT) && pre_ok;
  assign crc_init  = sfd_hit || eof_go;
  assign byte_full = {cd, sh};
  assign len_sat   = (byte_cnt > 16'd2047) ? 11'h7FF
                                           : byte_cnt[10:0];

  // end-of-frame status word
  always_comb begin
    stat               = 4'b0000;
    stat[STAT_FCS_BAD] = CHECK_FCS && (crc != CRC32_RESIDUE);
    stat[STAT_ALIGN]   = (didx != 2'd0);
    stat[STAT_RUNT]    = int'(byte_cnt) < ETH_MIN_FRAME;
    stat[STAT_GIANT]   = giant;
  end

  crc32_d8 u_crc (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .init      (crc_init),
    .en        (crc_en),
    .data      (byte_full),
    .crc       (crc)
  );

  // frame FSM: preamble qualification, dibit packing, counters
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_DROP;
      pcount   <= 5'd0;
      didx     <= 2'd0;
      sh       <= 6'd0;
      byte_cnt <= 16'd0;
      giant    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_PREAMBLE: begin
          if (ce) begin
            state  <= ST_IDLE;
            pcount <= 5'd0;
          end else if (cv) begin
            case (cd)
              ETH_PREAMBLE_DIBIT: begin
                state <= ST_PREAMBLE;
                if (pcount != 5'd31) pcount <= pcount + 5'd1;
              end
              ETH_SFD_DIBIT: begin
                state    <= pre_ok ? ST_DATA : ST_DROP;
                didx     <= 2'd0;
                sh       <= 6'd0;
                byte_cnt <= 16'd0;
                giant    <= 1'b0;
              end
              2'b00: begin
                state <= (pcount == 5'd0) ? ST_PREAMBLE : ST_DROP;
              end
              default: state <= ST_DROP;
            endcase
          end
        end
        ST_DATA: begin
          if (ce) begin
            state  <= ST_IDLE;
            pcount <= 5'd0;
            didx   <= 2'd0;
          end else if (cv) begin
            sh   <= {cd, sh[5:2]};
            didx <= didx + 2'd1;
            if (byte_go) begin
              if (room) byte_cnt <= byte_cnt + 16'd1;
              else      giant    <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (ce) begin
            state  <= ST_IDLE;
            pcount <= 5'd0;
          end
        end
        default: state <= ST_DROP;
      endcase
    end
  end

  // registered byte stream and end-of-frame report
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_status <= 4'd0;
      rx_len    <= 11'd0;
    end else begin
      rx_valid <= crc_en;
      rx_sof   <= crc_en && (byte_cnt == 16'd0);
      rx_eof   <= eof_go;
      if (crc_en) rx_data <= byte_full;
      if (eof_go) begin
        rx_status <= stat;
        rx_len    <= len_sat;
      end
    end
  end

endmodule
